test_if_arbiter: RTL and testbench
==================================

# test_if_arbiter

Round-robin arbiter that time-shares one `test_if` data lane among `NREQ` requesters. It sits between the requester modules and the single `test_if.mp` instance, driving the interface's `data` output from whichever requester currently owns the lane. Grant tenure is bounded by a hold limit taken from the interface parameter (`getFoo()`), so the limit is set by the interface instantiation rather than by the arbiter.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `MAX_HOLD`, `bus.getFoo()` evaluated as a localparam at elaboration: maximum consecutive grant cycles while others wait; legal range 1..255.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req_i`  input  NREQ  per-requester request level.
- `data_i`  input  NREQ  per-requester data bit.
- `gnt_o`  output  NREQ  registered one-hot grant.
- `busy_o`  output  1  registered; lane owned.
- `owner_o`  output  $clog2(NREQ)  registered index of the current owner.
- `bus`  modport  `test_if.mp`  shared lane; the arbiter drives `bus.data`.

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE: if any `req_i` is set, pick with `rr_pick` starting at `ptr`, then enter BUSY with `gnt_o` one-hot at the winner, `cnt`=0. Otherwise stay in IDLE.
- BUSY: `cnt` increments each cycle, saturating at `MAX_HOLD-1`.
  - Release when `req_i[owner]`=0, or when `cnt`==`MAX_HOLD-1` and some other `req_i` is set.
  - On release: `ptr`=owner+1 mod NREQ, then enter GAP.
  - If `cnt`==`MAX_HOLD-1` and only the owner requests, the owner keeps the grant and `cnt` reloads 0.
- GAP: one cycle with all `gnt_o` low, so consecutive owners never overlap. Next state is IDLE-equivalent arbitration: BUSY if any request is pending, else IDLE.
- `bus.data` = `data_i[owner]` when `busy_o`, else 0. This path is combinational from `data_i`.
- `busy_o` = |`gnt_o`. `owner_o` holds its last value when not busy.
- Round-robin order: search `ptr`, `ptr`+1, … wrapping at NREQ-1 to 0. `ptr` advances only on release.

## Timing
- Reset values: state=IDLE; `gnt_o`=0, `busy_o`=0, `owner_o`=0, `ptr`=0, `cnt`=0; `bus.data`=0.
- Grant latency is 1 cycle: a `req_i` sampled at edge N gives `gnt_o` high after edge N.
- Maximum tenure with contention is `MAX_HOLD` cycles, followed by exactly 1 GAP cycle.
- Worst-case wait for requester k is (NREQ-1)*(`MAX_HOLD`+1) cycles.
- A requester dropping `req_i` at edge N loses its grant after edge N. Its data is not forwarded after that edge.
- A requester raising `req_i` in the same cycle as a release competes in the GAP cycle's arbitration.
- An asynchronous `rst` mid-tenure clears `gnt_o` immediately (without waiting for a clock edge). Arbitration restarts at `ptr`=0 after reset deasserts.
- `MAX_HOLD`=1: every contended tenure is a single cycle.

## Configuration
- `TEST_IF_ARB_LOCK_EN` defined:
  - Adds input `lock_i` [NREQ].
  - While `lock_i[owner]` is high, hold-limit release is suppressed. Release happens only when `req_i[owner]` drops.
  - `cnt` still saturates at `MAX_HOLD-1`.
- Undefined: no `lock_i` port; the hold limit is always enforced.

## Structure
- Package `test_if_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_GAP} arb_state_t`.
  - Function `rr_next` for the pointer wrap.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `idx`, `any`.
- `test_if_arbiter` holds the FSM, `cnt`, `ptr`, the grant registers, and the bus mux.

## Test plan
- Reset: assert `rst` asynchronously mid-BUSY → `gnt_o`=0 and `busy_o`=0 before the next edge; after release, `req_i`=4'b0100 → `gnt_o`=4'b0100 one cycle later.
- Single requester, `MAX_HOLD`=5, `req_i`=4'b0001 held for 20 cycles → `gnt_o`=4'b0001 continuously, no GAP cycles.
- Contention, `req_i`=4'b1111, `MAX_HOLD`=5 → grants 0,1,2,3,0 in order, each 5 cycles long, with 1 GAP cycle between tenures.
- Early release: owner 2 drops `req_i` after 2 cycles while requester 0 waits → GAP, then `gnt_o`=4'b0001, then `ptr`=3.
- Data path: owner 1 with `data_i`=4'b0010 → `bus.data`=1; during GAP → `bus.data`=0.
- With `TEST_IF_ARB_LOCK_EN`: owner 0 holds `lock_i[0]`=1 for 12 cycles with `req_i`=4'b0011 → grant stays with 0 for 12 cycles, then moves to 1 after the GAP cycle.

Source files
------------

// File: rtl/test_if_arb_pkg.sv
`default_nettype none
//============================================================================
// Module      : test_if_arb_pkg
// Description : Shared types and helpers for the test_if round-robin arbiter.
//               Holds the FSM state encoding and the pointer wrap helper.
// Revision    : 1.0 - initial release
//============================================================================
package test_if_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  // Next round-robin position after cur, wrapping at n-1 back to 0.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage : test_if_arb_pkg
`default_nettype wire

// File: rtl/test_if_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : test_if
// Description : Single shared data lane. FOO is the grant hold limit used by
//               the arbiter; getFoo() exposes the same value to clients.
// Ports       : data - lane data bit (driven through modport mp)
// Revision    : 1.0 - initial release
//============================================================================
interface test_if #(
  parameter int FOO = 5
);

  logic data;

  function automatic int getFoo();
    return FOO;
  endfunction

  modport mp (
    output data,
    import getFoo
  );

endinterface : test_if
`default_nettype wire

// File: rtl/test_if_arbiter_pick.sv
`default_nettype none
//============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker. Searches req starting
//               at ptr, then ptr+1, ... wrapping at NREQ-1 back to 0.
// Ports       : req [NREQ]  request vector
//               ptr         highest-priority position
//               idx         index of the first set request found
//               any         at least one request is set
// Revision    : 1.0 - initial release
//============================================================================
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0]  req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic      [PTR_W-1:0] idx,
  output logic                  any
);

  always_comb begin
    int               v_sum;
    logic [PTR_W-1:0] v_cand;
    idx    = '0;
    any    = 1'b0;
    v_sum  = 0;
    v_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_sum = int'(ptr) + i;
      if (v_sum >= NREQ) begin
        v_sum = v_sum - NREQ;
      end
      v_cand = PTR_W'(v_sum);
      // First hit in rotated order wins; later hits are ignored.
      if (!any && req[v_cand]) begin
        any = 1'b1;
        idx = v_cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/test_if_arbiter.sv
`default_nettype none
//============================================================================
// Module      : test_if_arbiter
// Description : Round-robin arbiter time-sharing one test_if lane among NREQ
//               requesters. Tenure under contention is bounded by the
//               interface's hold limit; each handover inserts one GAP cycle
//               with no grant so owners never overlap.
// Ports       : clk, rst      clock, asynchronous active-high reset
//               req_i  [NREQ] request levels
//               data_i [NREQ] per-requester data bits
//               lock_i [NREQ] hold-limit override (TEST_IF_ARB_LOCK_EN only)
//               gnt_o  [NREQ] registered one-hot grant
//               busy_o        registered, lane owned
//               owner_o       registered owner index (held while idle)
//               bus           test_if.mp lane, bus.data driven here
// Config      : define TEST_IF_ARB_LOCK_EN to add lock_i.
// Revision    : 1.0 - initial release
//============================================================================
module test_if_arbiter
  import test_if_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic [NREQ-1:0]          req_i,
  input  wire logic [NREQ-1:0]          data_i,
`ifdef TEST_IF_ARB_LOCK_EN
  input  wire logic [NREQ-1:0]          lock_i,
`endif
  output logic      [NREQ-1:0]          gnt_o,
  output logic                          busy_o,
  output logic      [$clog2(NREQ)-1:0]  owner_o,
  test_if.mp                            bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 8;
  // Hold limit comes from the interface instance (same value as getFoo()).
  localparam int MAX_HOLD = bus.FOO;
  localparam logic [CNT_W-1:0] c_hold_lim = CNT_W'(MAX_HOLD - 1);

  arb_state_t        r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_n;
  logic [PTR_W-1:0]  r_ptr,   w_ptr_n;
  logic [PTR_W-1:0]  r_owner, w_owner_n;
  logic [NREQ-1:0]   r_gnt,   w_gnt_n;
  logic              r_busy;

  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [NREQ-1:0]   w_pick_oh;
  logic              w_at_lim;
  logic              w_others;
  logic              w_lock;
  logic              w_release;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req_i),
    .ptr (r_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_comb begin
    w_pick_oh             = '0;
    w_pick_oh[w_pick_idx] = 1'b1;
  end

`ifdef TEST_IF_ARB_LOCK_EN
  assign w_lock = lock_i[r_owner];
`else
  assign w_lock = 1'b0;
`endif

  assign w_at_lim  = (r_cnt == c_hold_lim);
  // Someone other than the owner is waiting.
  assign w_others  = |(req_i & ~r_gnt);
  assign w_release = !req_i[r_owner] || (w_at_lim && w_others && !w_lock);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ptr_n   = r_ptr;
    w_owner_n = r_owner;
    w_gnt_n   = r_gnt;
    case (r_state)
      ARB_IDLE, ARB_GAP: begin
        // GAP arbitrates exactly like IDLE, using the pointer advanced at release.
        if (w_pick_any) begin
          w_state_n = ARB_BUSY;
          w_gnt_n   = w_pick_oh;
          w_owner_n = w_pick_idx;
          w_cnt_n   = '0;
        end else begin
          w_state_n = ARB_IDLE;
          w_gnt_n   = '0;
        end
      end
      ARB_BUSY: begin
        if (w_release) begin
          w_state_n = ARB_GAP;
          w_gnt_n   = '0;
          w_cnt_n   = '0;
          w_ptr_n   = PTR_W'(rr_next(int'(r_owner), NREQ));
        end else if (w_at_lim) begin
          // Sole requester restarts its tenure; a locked owner saturates.
          w_cnt_n = w_others ? r_cnt : '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = ARB_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_owner <= w_owner_n;
      r_gnt   <= w_gnt_n;
      r_busy  <= |w_gnt_n;
    end
  end

  assign gnt_o    = r_gnt;
  assign busy_o   = r_busy;
  assign owner_o  = r_owner;
  // Combinational from data_i so the owner's bit reaches the lane this cycle.
  assign bus.data = r_busy ? data_i[r_owner] : 1'b0;

endmodule : test_if_arbiter
`default_nettype wire

// File: tb/tb_test_if_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_test_if_arbiter
// Description : Directed self-checking bench for test_if_arbiter with NREQ=4
//               and a hold limit of 5. Lock scenario is compiled only when
//               TEST_IF_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
module tb_test_if_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 5;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] data;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [1:0]      owner;

  int errors;
  int checks;

  test_if #(.FOO(HOLD)) bus ();

  test_if_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .data_i  (data),
`ifdef TEST_IF_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .busy_o  (busy),
    .owner_o (owner),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    lock = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seq [5];
    errors = 0;
    checks = 0;
    seq    = '{0, 1, 2, 3, 0};

    // Reset state
    do_reset();
    check("rst_gnt",   32'(gnt),      32'h0);
    check("rst_busy",  32'(busy),     32'h0);
    check("rst_owner", 32'(owner),    32'h0);
    check("rst_data",  32'(bus.data), 32'h0);

    // Single requester: continuous grant, no GAP cycles
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("solo_gnt_c%0d", i), 32'(gnt), 32'h1);
    end
    req = '0;
    tick();
    check("solo_drop_gnt",  32'(gnt),  32'h0);
    check("solo_drop_busy", 32'(busy), 32'h0);

    // Contention: 0,1,2,3,0 for 5 cycles each with one GAP between
    do_reset();
    req  = 4'b1111;
    data = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < HOLD; c++) begin
        tick();
        check($sformatf("rr_gnt_t%0d_c%0d", t, c), 32'(gnt), 32'(1 << seq[t]));
        check($sformatf("rr_own_t%0d_c%0d", t, c), 32'(owner), 32'(seq[t]));
        check($sformatf("rr_data_t%0d_c%0d", t, c), 32'(bus.data), (seq[t] == 1) ? 32'h1 : 32'h0);
      end
      if (t < 4) begin
        tick();
        check($sformatf("rr_gap_gnt_t%0d", t),  32'(gnt),      32'h0);
        check($sformatf("rr_gap_busy_t%0d", t), 32'(busy),     32'h0);
        check($sformatf("rr_gap_data_t%0d", t), 32'(bus.data), 32'h0);
        check($sformatf("rr_gap_own_t%0d", t),  32'(owner),    32'(seq[t]));
      end
    end

    // Early release: owner 2 leaves after 2 cycles while 0 waits
    do_reset();
    req = 4'b0100;
    tick();
    check("early_gnt_c0", 32'(gnt), 32'h4);
    req = 4'b0101;
    tick();
    check("early_gnt_c1", 32'(gnt), 32'h4);
    req = 4'b0001;
    tick();
    check("early_gap", 32'(gnt), 32'h0);
    tick();
    check("early_next_gnt", 32'(gnt), 32'h1);
    check("early_ptr",      32'(dut.r_ptr), 32'h3);

    // Asynchronous reset mid-tenure
    do_reset();
    req = 4'b0001;
    tick();
    check("arst_pre_gnt", 32'(gnt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt",  32'(gnt),  32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    #1;
    rst = 1'b0;
    req = 4'b0100;
    tick();
    check("arst_regnt", 32'(gnt), 32'h4);

`ifdef TEST_IF_ARB_LOCK_EN
    // Lock: owner 0 keeps the lane past the hold limit
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("lock_gnt_c%0d", i), 32'(gnt), 32'h1);
    end
    lock = '0;
    tick();
    check("lock_gap", 32'(gnt), 32'h0);
    tick();
    check("lock_next_gnt", 32'(gnt), 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_test_if_arbiter
`default_nettype wire
